// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, ALU + queued memory write-back, load scoreboard. Optional macro: REGFILE_BYPASS_EN.
// Latency: reads combinational; a write is visible the cycle after its commit edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: mem_ready low while the write-back queue is full; mem_we then is dropped and sets sticky wbq_ovf.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 2,
    parameter int WBQ_DEPTH = 2,
    parameter int ZERO_REG  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       alu_we,
    input  logic [ADDR_W-1:0]          alu_waddr,
    input  logic [DATA_W-1:0]          alu_wdata,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_waddr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_ready,
    input  logic                       ld_issue,
    input  logic [ADDR_W-1:0]          ld_dest,
    output logic [(1<<ADDR_W)-1:0]     busy,
    output logic                       wbq_ovf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int QW    = $clog2(WBQ_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wbq_ent_t;

    logic [DATA_W-1:0] regs [DEPTH];
    wbq_ent_t          wbq  [WBQ_DEPTH];
    logic [QW-1:0]     rd_ptr, wr_ptr;
    logic [QW:0]       cnt;

    logic              q_empty, mem_acc, push, pop, set_en, arr_we;
    logic              wr_en, wr_mem;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;

    assign q_empty   = (cnt == '0);
    assign mem_ready = (cnt != (QW+1)'(WBQ_DEPTH));
    assign mem_acc   = mem_we && mem_ready;
    assign pop       = !rst && !alu_we && !q_empty;
    // A load only bypasses the queue when nothing older is waiting in it.
    assign push      = !rst && mem_acc && (alu_we || !q_empty);
    assign set_en    = ld_issue && !((ZERO_REG != 0) && (ld_dest == '0));

    always_comb begin
        wr_en   = 1'b0;
        wr_mem  = 1'b0;
        wr_addr = '0;
        wr_dat  = '0;
        if (!rst) begin
            if (alu_we) begin
                wr_en   = 1'b1;
                wr_addr = alu_waddr;
                wr_dat  = alu_wdata;
            end else if (!q_empty) begin
                wr_en   = 1'b1;
                wr_mem  = 1'b1;
                wr_addr = wbq[rd_ptr].addr;
                wr_dat  = wbq[rd_ptr].dat;
            end else if (mem_we) begin
                wr_en   = 1'b1;
                wr_mem  = 1'b1;
                wr_addr = mem_waddr;
                wr_dat  = mem_wdata;
            end
        end
    end

    assign arr_we = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            wbq[wr_ptr] <= '{addr: mem_waddr, dat: mem_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            busy    <= '0;
            wbq_ovf <= 1'b0;
        end else begin
            if (arr_we) begin
                regs[wr_addr] <= wr_dat;
            end
            if (push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (QW+1)'(1);
                2'b01:   cnt <= cnt - (QW+1)'(1);
                default: cnt <= cnt;
            endcase
            // Set is applied after clear so a same-cycle reissue keeps the register busy.
            if (wr_mem) begin
                busy[wr_addr] <= 1'b0;
            end
            if (set_en) begin
                busy[ld_dest] <= 1'b1;
            end
            if (mem_we && !mem_ready) begin
                wbq_ovf <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] arr_dat;

        assign ra      = raddr[i*ADDR_W +: ADDR_W];
        assign arr_dat = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
        logic clr_hit, set_hit;
        assign clr_hit = wr_mem && (wr_addr == ra);
        assign set_hit = set_en && (ld_dest == ra);
        assign rdata[i*DATA_W +: DATA_W] = (arr_we && (wr_addr == ra)) ? wr_dat : arr_dat;
        assign rd_busy[i] = clr_hit ? set_hit : busy[ra];
`else
        assign rdata[i*DATA_W +: DATA_W] = arr_dat;
        assign rd_busy[i] = busy[ra];
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (ZERO_REG=1, defaults otherwise): directed scenarios plus random traffic vs a queue-based model.
module tb_regfile_mp;
    localparam int DW = 32, AW = 4, NR = 2, QD = 2, NREG = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rd_busy;
    logic              alu_we, mem_we, ld_issue, mem_ready, wbq_ovf;
    logic [AW-1:0]     alu_waddr, mem_waddr, ld_dest;
    logic [DW-1:0]     alu_wdata, mem_wdata;
    logic [NREG-1:0]   busy;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .WBQ_DEPTH(QD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .ld_issue(ld_issue), .ld_dest(ld_dest), .busy(busy), .wbq_ovf(wbq_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: register array, FIFO of pending loads, busy bits, sticky overflow.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_busy;
    ent_t            m_q [$];
    bit              m_ovf;

    // Which write reaches the array this cycle: ALU first, then oldest queued load, then a direct load.
    function automatic void m_commit(output bit en, output bit ism, output logic [AW-1:0] a, output logic [DW-1:0] d);
        en = 0; ism = 0; a = '0; d = '0;
        if (rst) return;
        if (alu_we) begin
            en = 1; a = alu_waddr; d = alu_wdata;
        end else if (m_q.size() > 0) begin
            en = 1; ism = 1; a = m_q[0].a; d = m_q[0].d;
        end else if (mem_we) begin
            en = 1; ism = 1; a = mem_waddr; d = mem_wdata;
        end
    endfunction

    task automatic m_update();
        bit en, ism, ready, had;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (rst) begin
            for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            m_busy = '0;
            m_q.delete();
            m_ovf = 0;
            return;
        end
        m_commit(en, ism, a, d);
        ready = (m_q.size() != QD);
        had   = (m_q.size() != 0);
        if (mem_we && !ready) m_ovf = 1;
        if (en && a != 0) m_regs[a] = d;
        if (en && ism) m_busy[a] = 1'b0;
        if (!alu_we && had) void'(m_q.pop_front());
        if (mem_we && ready && (alu_we || had)) m_q.push_back('{a: mem_waddr, d: mem_wdata});
        if (ld_issue && ld_dest != 0) m_busy[ld_dest] = 1'b1;
    endtask

    function automatic logic [DW-1:0] exp_rdata(int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        begin
            bit en, ism;
            logic [AW-1:0] ca;
            logic [DW-1:0] cd;
            m_commit(en, ism, ca, cd);
            if (en && ca == a) return cd;
        end
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_rd_busy(int i);
        logic [AW-1:0] a;
        logic b;
        a = raddr[i*AW +: AW];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        begin
            bit en, ism;
            logic [AW-1:0] ca;
            logic [DW-1:0] cd;
            m_commit(en, ism, ca, cd);
            if (en && ism && ca == a) b = ld_issue && ld_dest == a && a != 0;
        end
`endif
        return b;
    endfunction

    task automatic idle();
        alu_we = 0; alu_waddr = '0; alu_wdata = '0;
        mem_we = 0; mem_waddr = '0; mem_wdata = '0;
        ld_issue = 0; ld_dest = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        idle(); alu_we = 1; alu_waddr = 5; alu_wdata = 32'h1234; tick();
        idle(); raddr = {4'd0, 4'd5}; #2;
        checks++; if (rdata[31:0] !== 32'h1234) begin errors++; $display("FAIL reset_pre_r5 got %h exp %h", rdata[31:0], 32'h1234); end
        // Fill queue past capacity and mark a register busy, then reset.
        alu_we = 1; alu_waddr = 1; alu_wdata = 32'h11; mem_we = 1; mem_waddr = 2; mem_wdata = 32'h22;
        ld_issue = 1; ld_dest = 9;
        tick(); tick(); tick();
        #2;
        checks++; if (wbq_ovf !== 1'b1) begin errors++; $display("FAIL reset_pre_ovf got %b exp 1", wbq_ovf); end
        checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy9 got %b exp 1", busy[9]); end
        idle(); rst = 1; alu_we = 1; alu_waddr = 6; alu_wdata = 32'h99; tick();
        rst = 0; idle(); raddr = {4'd6, 4'd5}; #2;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h exp 0", rdata[31:0]); end
        checks++; if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL reset_r6_ignored got %h exp 0", rdata[63:32]); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b exp 00", rd_busy); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
        checks++; if (wbq_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", wbq_ovf); end
        tick(); raddr = {4'd1, 4'd2}; tick(); #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL reset_q_discard got %h exp 0", rdata[31:0]); end
    endtask

    task automatic test_collision();
        idle(); alu_we = 1; alu_waddr = 3; alu_wdata = 32'hA; mem_we = 1; mem_waddr = 4; mem_wdata = 32'hB;
        raddr = {4'd4, 4'd3}; tick();
        idle(); #2;
        checks++; if (rdata[31:0] !== 32'hA) begin errors++; $display("FAIL coll_r3 got %h exp %h", rdata[31:0], 32'hA); end
        checks++; if (rdata[63:32] !== exp_rdata(1)) begin errors++; $display("FAIL coll_r4_pre got %h exp %h", rdata[63:32], exp_rdata(1)); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b exp 1", mem_ready); end
        tick(); #1;
        checks++; if (rdata[63:32] !== 32'hB) begin errors++; $display("FAIL coll_r4 got %h exp %h", rdata[63:32], 32'hB); end
        // Queue now empty: a load commits directly in one cycle.
        mem_we = 1; mem_waddr = 4; mem_wdata = 32'hC; tick(); idle(); #1;
        checks++; if (rdata[63:32] !== 32'hC) begin errors++; $display("FAIL coll_direct got %h exp %h", rdata[63:32], 32'hC); end
    endtask

    task automatic test_queue_full();
        idle(); alu_we = 1; alu_waddr = 1; alu_wdata = 32'h5;
        mem_we = 1; mem_waddr = 10; mem_wdata = 32'h100; tick();
        mem_waddr = 11; mem_wdata = 32'h200; tick(); #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL qf_ready got %b exp 0", mem_ready); end
        mem_waddr = 12; mem_wdata = 32'h300; tick(); #1;
        checks++; if (wbq_ovf !== 1'b1) begin errors++; $display("FAIL qf_ovf got %b exp 1", wbq_ovf); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL qf_ready_held got %b exp 0", mem_ready); end
        idle(); raddr = {4'd11, 4'd10}; tick(); #1;
        checks++; if (rdata[31:0] !== 32'h100) begin errors++; $display("FAIL qf_first got %h exp %h", rdata[31:0], 32'h100); end
        checks++; if (rdata[63:32] !== exp_rdata(1)) begin errors++; $display("FAIL qf_mid got %h exp %h", rdata[63:32], exp_rdata(1)); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL qf_ready_drain got %b exp 1", mem_ready); end
        tick(); raddr = {4'd11, 4'd12}; #1;
        checks++; if (rdata[63:32] !== 32'h200) begin errors++; $display("FAIL qf_second got %h exp %h", rdata[63:32], 32'h200); end
        tick(); #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL qf_dropped got %h exp 0", rdata[31:0]); end
    endtask

    task automatic test_scoreboard();
        idle(); raddr = {4'd0, 4'd7}; ld_issue = 1; ld_dest = 7; tick();
        idle(); #1;
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", busy[7]); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy got %b exp 1", rd_busy[0]); end
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'h55; #1;
        checks++; if (rd_busy[0] !== exp_rd_busy(0)) begin errors++; $display("FAIL sb_rd_busy_commit got %b exp %b", rd_busy[0], exp_rd_busy(0)); end
        tick(); idle(); #1;
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", busy[7]); end
        checks++; if (rdata[31:0] !== 32'h55) begin errors++; $display("FAIL sb_data got %h exp %h", rdata[31:0], 32'h55); end
        ld_issue = 1; ld_dest = 7; tick();
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'h66; #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_rd_busy_setwins got %b exp 1", rd_busy[0]); end
        tick(); idle(); #1;
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_setwins got %b exp 1", busy[7]); end
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'h67; tick(); idle();
    endtask

    task automatic test_zero_reg();
        idle(); raddr = {4'd0, 4'd0}; alu_we = 1; alu_waddr = 0; alu_wdata = 32'hFFFF;
        ld_issue = 1; ld_dest = 0; tick();
        idle(); mem_we = 1; mem_waddr = 0; mem_wdata = 32'hDEAD; #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL zero_alu got %h exp 0", rdata[31:0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy[0]); end
        tick(); idle(); #1;
        checks++; if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL zero_mem got %h exp 0", rdata[63:32]); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'h77;
`else
        want = 32'h0;
`endif
        idle(); raddr = {4'd0, 4'd2}; alu_we = 1; alu_waddr = 2; alu_wdata = 32'h77; #1;
        checks++; if (rdata[31:0] !== want) begin errors++; $display("FAIL byp_same got %h exp %h", rdata[31:0], want); end
        tick(); idle(); #1;
        checks++; if (rdata[31:0] !== 32'h77) begin errors++; $display("FAIL byp_next got %h exp %h", rdata[31:0], 32'h77); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 79) == 0);
            alu_we    = ($urandom_range(0, 99) < 45);
            alu_waddr = AW'($urandom_range(0, 7));
            alu_wdata = $urandom;
            mem_we    = ($urandom_range(0, 99) < 60);
            mem_waddr = AW'($urandom_range(0, 7));
            mem_wdata = $urandom;
            ld_issue  = ($urandom_range(0, 99) < 35);
            ld_dest   = AW'($urandom_range(0, 7));
            raddr     = {AW'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? mem_waddr : alu_waddr};
            #2;
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (rdata[i*DW +: DW] !== exp_rdata(i)) begin
                    errors++; $display("FAIL rnd_rdata%0d cyc %0d got %h exp %h", i, c, rdata[i*DW +: DW], exp_rdata(i));
                end
                checks++;
                if (rd_busy[i] !== exp_rd_busy(i)) begin
                    errors++; $display("FAIL rnd_rd_busy%0d cyc %0d got %b exp %b", i, c, rd_busy[i], exp_rd_busy(i));
                end
            end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %h exp %h", c, busy, m_busy); end
            checks++;
            if (mem_ready !== (m_q.size() != QD)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, mem_ready, m_q.size() != QD);
            end
            checks++; if (wbq_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", c, wbq_ovf, m_ovf); end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        idle(); raddr = '0; rst = 1;
        tick(); tick();
        rst = 0;
        test_reset();
        test_collision();
        test_queue_full();
        test_scoreboard();
        test_zero_reg();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the micro CPU, replacing the fixed 16×32, 2-read/1-write file. It provides NUM_RD combinational read ports, and one ALU write-back port that always commits in its cycle. A memory write-back port is buffered through a small in-order queue, so ALU and load results never collide on the single array write port. A load scoreboard (per-register busy bits) is maintained for the decode-stage stall logic.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2^ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- WBQ_DEPTH, 2, memory write-back queue entries (power of 2, ≥2)
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never marked busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i address has a pending load
- alu_we  in  1  ALU write-back valid
- alu_waddr  in  ADDR_W  ALU destination
- alu_wdata  in  DATA_W  ALU result
- mem_we  in  1  memory write-back valid
- mem_waddr  in  ADDR_W  load destination
- mem_wdata  in  DATA_W  load data
- mem_ready  out  1  queue can accept mem_we this cycle
- ld_issue  in  1  load issued; marks ld_dest busy
- ld_dest  in  ADDR_W  destination of issued load
- busy  out  2^ADDR_W  scoreboard vector
- wbq_ovf  out  1  sticky: mem_we seen while mem_ready=0

## Operation
- Reads are combinational from the array; rdata = 0 when ZERO_REG=1 and the address is 0.
- One array write per cycle, priority: ALU > queue head > direct memory.
  - alu_we=1: the ALU write commits; any mem_we is enqueued.
  - alu_we=0, queue non-empty: the head commits and is popped; any mem_we is enqueued behind it (order preserved).
  - alu_we=0, queue empty, mem_we=1: direct commit, no enqueue.
- Queue: circular buffer, rd/wr pointers plus count; push and pop in the same cycle are legal when not full.
- mem_ready = (count != WBQ_DEPTH), registered-state only; it does not depend on alu_we.
- mem_we with mem_ready=0 drops the write and sets wbq_ovf until rst.
- Scoreboard:
  - ld_issue sets busy[ld_dest].
  - A committed memory write (direct or head) clears busy[addr].
  - Set and clear of the same address in one cycle: set wins.
  - ALU writes do not touch busy.
- Same-address ALU and memory in one cycle: ALU value lands first, memory value overwrites on a later cycle.
- rd_busy[i] = busy[raddr_i].

## Timing
- Read latency 0 (combinational); write visible to reads the cycle after the commit edge, unless bypass is enabled.
- Direct memory write: 1 cycle. Queued write: commits at the first edge with alu_we=0 and the entry at the head.
- Worst-case drain with alu_we held low: WBQ_DEPTH cycles.
- Reset (rst=1 at edge):
  - all registers 0, queue empty
  - busy=0, wbq_ovf=0
  - outputs: rdata=0, rd_busy=0, mem_ready=1
  - in-flight queue entries are discarded, including mid-drain; write inputs are ignored during the reset cycle.

## Configuration
- REGFILE_BYPASS_EN defined: rdata forwards the data being committed this cycle when its address matches raddr (ALU, head or direct). rd_busy also reads 0 for an address whose busy bit is being cleared this cycle, unless ld_issue sets that same address in the same cycle, in which case rd_busy=1.
- REGFILE_BYPASS_EN undefined: rdata and rd_busy reflect array and scoreboard contents only (the old value during the commit cycle).

## Test plan
- Reset: write R5=0x1234 then assert rst for 1 cycle -> R5 reads 0, busy=0, mem_ready=1, wbq_ovf=0.
- Collision: alu_we R3=0xA, mem_we R4=0xB same cycle -> R3=0xA next cycle; R4=0xB one cycle later with alu_we=0; queue count 1 then 0.
- Queue full: WBQ_DEPTH=2, alu_we held 1, three consecutive mem_we -> mem_ready=0 after two, third dropped, wbq_ovf=1; drain commits exactly two in order.
- Scoreboard: ld_issue R7 -> busy[7]=1, rd_busy=1 on a port reading R7; mem write R7=0x55 commits -> busy[7]=0 next cycle. Same-cycle ld_issue R7 with R7 commit -> busy[7] stays 1.
- ZERO_REG=1: alu_we R0=0xFFFF, ld_issue R0 -> R0 reads 0, busy[0]=0.
- Bypass (REGFILE_BYPASS_EN): alu_we R2=0x77 with raddr0=R2 -> rdata0=0x77 same cycle. Without the macro -> old value that cycle, 0x77 next.
